// File: rtl/tap_decoder.sv
// Groups single-cycle rise_edge pulses into bursts and reports the tap count
// (saturating, with overflow) once a burst has been quiet for GAP_CYCLES cycles.
module tap_decoder #(
  parameter int GAP_CYCLES = 16,
  parameter int MAX_TAPS   = 3,
  parameter int TAP_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise_edge,
  input  logic             en,
  output logic             tap_valid,
  output logic [TAP_W-1:0] tap_count,
  output logic             overflow,
  output logic             busy
);

  localparam int                GW       = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TAP_W-1:0]  CNT_MAX  = TAP_W'(MAX_TAPS);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           state, state_d;
  logic [TAP_W-1:0] cnt, cnt_d;
  logic             ovf, ovf_d;
  logic [GW-1:0]    gap, gap_d;
  logic             valid_d, ovf_out_d;
  logic [TAP_W-1:0] count_d;
  logic             tap, burst_end;

  assign tap       = rise_edge & en;
  // A tap on the last quiet cycle wins over the burst end and extends it.
  assign burst_end = (state == COUNT) && !tap && (gap == GAP_LAST);
  assign busy      = (state == COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ovf       <= 1'b0;
      gap       <= '0;
      tap_valid <= 1'b0;
      tap_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ovf       <= ovf_d;
      gap       <= gap_d;
      tap_valid <= valid_d;
      tap_count <= count_d;
      overflow  <= ovf_out_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (tap)       state_d = COUNT;
      COUNT:   if (burst_end) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt;
    ovf_d     = ovf;
    gap_d     = gap;
    valid_d   = 1'b0;
    count_d   = tap_count;
    ovf_out_d = overflow;
    if (state == IDLE) begin
      if (tap) begin
        cnt_d = TAP_W'(1);
        ovf_d = 1'b0;
        gap_d = '0;
      end
    end else if (tap) begin
      if (cnt < CNT_MAX) cnt_d = cnt + 1'b1;
      else               ovf_d = 1'b1;
      gap_d = '0;
    end else if (burst_end) begin
      valid_d   = 1'b1;
      count_d   = cnt;
      ovf_out_d = ovf;
    end else begin
      gap_d = gap + 1'b1;
    end
  end

endmodule

// File: tb/tb_tap_decoder.sv
// Directed scenarios for tap_decoder; expected reports go on a scoreboard
// queue and are popped when tap_valid fires (or was due).
module tb_tap_decoder;
  localparam int GAP = 16, MAXT = 3, TW = 2;

  logic          clk = 1'b0, rst_n = 1'b0, rise_edge = 1'b0, en = 1'b0;
  logic          tap_valid, overflow, busy;
  logic [TW-1:0] tap_count;

  tap_decoder #(.GAP_CYCLES(GAP), .MAX_TAPS(MAXT), .TAP_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rise_edge(rise_edge), .en(en),
    .tap_valid(tap_valid), .tap_count(tap_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int cnt; logic ovf;} rep_t;
  rep_t sb[$];
  int   taps[$];
  bit   exp_busy [0:127];
  int   ncmp = 0, nerr = 0, cyc = 0, en_from = 0, hold_cnt = 0;
  logic hold_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_rep(input int c, input int n, input logic o);
    rep_t r;
    r.cyc = c; r.cnt = n; r.ovf = o;
    sb.push_back(r);
  endtask

  task automatic set_busy(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic new_scn();
    taps.delete();
    sb.delete();
    for (int i = 0; i < 128; i++) exp_busy[i] = 1'b0;
    en_from = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rise_edge = 1'b0; en = 1'b0;
    @(negedge clk);
    check("rst_tap_valid", 32'(tap_valid), 0);
    check("rst_tap_count", 32'(tap_count), 0);
    check("rst_overflow",  32'(overflow),  0);
    check("rst_busy",      32'(busy),      0);
    rst_n = 1'b1;
    cyc = 0; hold_cnt = 0; hold_ovf = 1'b0;
  endtask

  // One clock: check outputs of cycle cyc, drive inputs for cycle cyc, advance.
  task automatic step(input int rst_at);
    rep_t r;
    bit   t;
    check("busy", 32'(busy), 32'(exp_busy[cyc]));
    if (tap_valid !== 1'b0 || (sb.size() > 0 && sb[0].cyc == cyc)) begin
      if (sb.size() == 0) check("spurious_valid", 32'(tap_valid), 0);
      else begin
        r = sb.pop_front();
        check("tap_valid", 32'(tap_valid), 1);
        check("report_cycle", 32'(cyc), 32'(r.cyc));
        hold_cnt = r.cnt; hold_ovf = r.ovf;
      end
    end
    check("tap_count", 32'(tap_count), 32'(hold_cnt));
    check("overflow",  32'(overflow),  32'(hold_ovf));
    t = 1'b0;
    foreach (taps[i]) if (taps[i] == cyc) t = 1'b1;
    rise_edge = t;
    en = (cyc >= en_from);
    if (cyc == rst_at) begin
      rst_n = 1'b0;
      #1;
      check("busy_async_rst", 32'(busy), 0);
      check("valid_async_rst", 32'(tap_valid), 0);
      check("count_async_rst", 32'(tap_count), 0);
      check("ovf_async_rst", 32'(overflow), 0);
      hold_cnt = 0; hold_ovf = 1'b0;
    end else if (cyc == rst_at + 1) begin
      rst_n = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n, input int rst_at);
    while (cyc < n) step(rst_at);
    rise_edge = 1'b0;
    check("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    // single tap
    new_scn(); taps = '{10}; push_rep(27, 1, 1'b0); set_busy(11, 26);
    do_reset(); run(40, -10);
    // double tap
    new_scn(); taps = '{10, 20}; push_rep(37, 2, 1'b0); set_busy(11, 36);
    do_reset(); run(50, -10);
    // overflow, values held through cycle 100
    new_scn(); taps = '{10, 14, 18, 22, 26}; push_rep(43, 3, 1'b1); set_busy(11, 42);
    do_reset(); run(101, -10);
    // tap on last quiet cycle extends the burst
    new_scn(); taps = '{10, 26}; push_rep(43, 2, 1'b0); set_busy(11, 42);
    do_reset(); run(60, -10);
    // tap coincident with tap_valid starts a new burst
    new_scn(); taps = '{10, 27}; push_rep(27, 1, 1'b0); push_rep(44, 1, 1'b0);
    set_busy(11, 26); set_busy(28, 43);
    do_reset(); run(60, -10);
    // back-to-back taps both count
    new_scn(); taps = '{10, 11}; push_rep(28, 2, 1'b0); set_busy(11, 27);
    do_reset(); run(40, -10);
    // en low ignores taps; mid-burst reset discards burst
    new_scn(); en_from = 10; taps = '{5, 8, 10, 30}; push_rep(47, 1, 1'b0);
    set_busy(11, 15); set_busy(31, 46);
    do_reset(); run(60, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/tap_decoder.md
# tap_decoder

Consumes the single-cycle `rise_edge` pulses produced by the synchronizer/edge-detector stage and groups them into bursts ("taps"). A burst ends after a fixed number of quiet cycles. At that point the block emits a one-cycle `tap_valid` report carrying the number of taps in the burst (1..MAX_TAPS) and an overflow flag. Downstream control logic uses the report to distinguish single, double and triple presses of a pushbutton.

## Interface
- `GAP_CYCLES`, default 16: number of consecutive quiet cycles after the last tap that ends a burst; legal range ≥ 2.
- `MAX_TAPS`, default 3: saturation value of the tap count; legal range 1 ≤ MAX_TAPS < 2^TAP_W.
- `TAP_W`, default 2: width of `tap_count`.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `rise_edge`  input  1: one-cycle tap pulse from the edge-detect stage, synchronous to `clk`.
- `en`  input  1: tap enable; while low, `rise_edge` is ignored.
- `tap_valid`  output  1: one-cycle pulse marking the end of a burst.
- `tap_count`  output  TAP_W: taps in the reported burst, saturated at MAX_TAPS; held until the next report.
- `overflow`  output  1: high when the reported burst contained more than MAX_TAPS taps; held until the next report.
- `busy`  output  1: a burst is in progress.

## Operation
- A tap is a cycle with `rise_edge & en` high.
- Two states: IDLE and COUNT. `busy` is high exactly when the state is COUNT.
- **IDLE:**
  - On a tap: go to COUNT, set the internal tap counter to 1, clear the internal overflow flag, clear the gap timer.
  - Otherwise: remain in IDLE.
- **COUNT, on a tap:**
  - If the counter is below MAX_TAPS, increment it.
  - Otherwise hold it at MAX_TAPS and set the internal overflow flag.
  - Clear the gap timer.
- **COUNT, on a quiet cycle:**
  - If the gap timer equals GAP_CYCLES-1: register `tap_valid`=1, copy the counter to `tap_count`, copy the overflow flag to `overflow`, go to IDLE.
  - Otherwise: increment the gap timer.
- Gap timer width is $clog2(GAP_CYCLES); it never wraps, because it is cleared or the burst ends first.
- `tap_count` and `overflow` change only in the cycle `tap_valid` rises.
- `en` gates taps in both states. Gap timing continues while `en` is low, so a burst in progress still ends normally.
- **Reset** (`rst_n` low, at any time including mid-burst):
  - State goes to IDLE immediately.
  - All counters and flags clear.
  - `tap_valid`=0, `tap_count`=0, `overflow`=0, `busy`=0.
  - An interrupted burst is discarded with no report.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- A tap in cycle T with no tap earlier in that burst: `busy` is high from cycle T+1.
- Burst end: the last tap is in cycle T and cycles T+1..T+GAP_CYCLES are quiet.
  - `busy` falls in cycle T+GAP_CYCLES+1.
  - `tap_valid` is high in cycle T+GAP_CYCLES+1 only.
  - Report latency from the last tap is therefore GAP_CYCLES+1 cycles.
- A tap in cycle T+GAP_CYCLES (the last would-be quiet cycle) extends the burst; no report is made.
- A tap in the same cycle `tap_valid` is high: the block is already in IDLE, so the tap starts a new burst with count 1.
- Back-to-back taps in consecutive cycles each count.
- Maximum report rate: one report per GAP_CYCLES+1 cycles.

## Test plan
All scenarios use GAP_CYCLES=16, MAX_TAPS=3, `en`=1 unless stated; cycle numbers are counted from reset release.
- **Single tap:** tap in cycle 10 -> `busy` high in cycles 11..26; `tap_valid` only in cycle 27 with `tap_count`=1, `overflow`=0.
- **Double tap:** taps in cycles 10 and 20 -> single `tap_valid` in cycle 37 with `tap_count`=2, `overflow`=0.
- **Overflow:** taps in cycles 10, 14, 18, 22, 26 -> `tap_valid` in cycle 43 with `tap_count`=3, `overflow`=1. Both values are held through cycle 100.
- **Gap boundary, burst extended:** taps in cycles 10 and 26 -> one report in cycle 43 with `tap_count`=2.
- **Gap boundary, new burst:** taps in cycles 10 and 27 -> report in cycle 27 with count 1, then a report in cycle 44 with count 1.
- **Enable and mid-burst reset:**
  - `en`=0 with taps in cycles 5 and 8 -> `busy` and `tap_valid` stay 0.
  - `en`=1, tap in cycle 10, `rst_n` pulsed low in cycle 15 -> `busy` drops immediately; no `tap_valid` ever appears; `tap_count`=0, `overflow`=0.
  - A following tap in cycle 30 -> report in cycle 47 with count 1.
